// File: rtl/isa_fetch.sv
// isa_fetch: fetches a contiguous ISA program from DRAM in bursts of up to MAX_BURST words,
// buffers it in a first-word-fall-through FIFO and streams it to the CCU decoder.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   TOPITF_*              start pulse, program byte address and length (words)
//   ITFTOP_Busy/Done      busy level from accepted start; one-cycle completion pulse
//   ITFDRM_RdReq*/RdAddr/RdLen, DRMITF_RdReqRdy   DRAM burst read request channel
//   DRMITF_RdDat/RdDatVld, ITFDRM_RdDatRdy        DRAM read data channel
//   ITFCCU_ISARdDat*/CCUITF_ISARdDatRdy           ISA word stream to the CCU
module isa_fetch #(
    parameter int unsigned PORT_WIDTH      = 128,
    parameter int unsigned DRAM_ADDR_WIDTH = 32,
    parameter int unsigned NUM_WORD_WIDTH  = 16,
    parameter int unsigned MAX_BURST       = 8,
    parameter int unsigned FIFO_ADDR_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       TOPITF_Start,
    input  logic [DRAM_ADDR_WIDTH-1:0] TOPITF_BaseAddr,
    input  logic [NUM_WORD_WIDTH-1:0]  TOPITF_NumWord,
    output logic                       ITFTOP_Busy,
    output logic                       ITFTOP_Done,
    output logic                       ITFDRM_RdReqVld,
    input  logic                       DRMITF_RdReqRdy,
    output logic [DRAM_ADDR_WIDTH-1:0] ITFDRM_RdAddr,
    output logic [7:0]                 ITFDRM_RdLen,
    input  logic [PORT_WIDTH-1:0]      DRMITF_RdDat,
    input  logic                       DRMITF_RdDatVld,
    output logic                       ITFDRM_RdDatRdy,
    output logic [PORT_WIDTH-1:0]      ITFCCU_ISARdDat,
    output logic                       ITFCCU_ISARdDatVld,
    output logic                       ITFCCU_ISARdDatLast,
    input  logic                       CCUITF_ISARdDatRdy
);

    localparam int unsigned Depth        = 1 << FIFO_ADDR_WIDTH;
    localparam int unsigned CntW         = FIFO_ADDR_WIDTH + 1;
    localparam int unsigned SumW         = CntW + 9;
    localparam int unsigned BytesPerWord = PORT_WIDTH / 8;

    localparam logic [NUM_WORD_WIDTH-1:0] MaxBurstW = NUM_WORD_WIDTH'(MAX_BURST);

    typedef enum logic [1:0] {StIdle, StReq, StDrain, StDone} state_e;

    state_e                     state_q;
    logic [DRAM_ADDR_WIDTH-1:0] addr_q;
    logic [NUM_WORD_WIDTH-1:0]  remain_req_q;
    logic [NUM_WORD_WIDTH-1:0]  remain_pop_q;
    logic [CntW-1:0]            inflight_q, inflight_d;
    logic [CntW-1:0]            count_q, count_d;
    logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic                       busy_q, done_q;
    logic [PORT_WIDTH-1:0]      mem_q [Depth];

    logic [NUM_WORD_WIDTH-1:0] len_w;
    logic [7:0]                len;
    logic                      credit_ok, req_vld, req_hs;
    logic                      fifo_full, fifo_empty, running;
    logic                      push, pop, last_pop;

    always_comb begin
        len_w      = (remain_req_q > MaxBurstW) ? MaxBurstW : remain_req_q;
        len        = 8'(len_w);
        // Buffered plus outstanding words must fit in the FIFO before a new burst goes out.
        credit_ok  = (SumW'(count_q) + SumW'(inflight_q) + SumW'(len)) <= SumW'(Depth);
        req_vld    = (state_q == StReq) && credit_ok;
        req_hs     = req_vld && DRMITF_RdReqRdy;
        fifo_full  = (count_q == CntW'(Depth));
        fifo_empty = (count_q == '0);
        running    = (state_q == StReq) || (state_q == StDrain);
        // Beats outside a running program (after an abort) are accepted and dropped.
        push       = DRMITF_RdDatVld && !fifo_full && running;
        pop        = !fifo_empty && CCUITF_ISARdDatRdy;
        last_pop   = pop && (remain_pop_q == NUM_WORD_WIDTH'(1));
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end
        inflight_d = inflight_q;
        if (req_hs) begin
            inflight_d = inflight_d + CntW'(len);
        end
        if (push) begin
            inflight_d = inflight_d - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            remain_req_q <= '0;
            remain_pop_q <= '0;
            inflight_q   <= '0;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + FIFO_ADDR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + FIFO_ADDR_WIDTH'(1);
                if (remain_pop_q != '0) begin
                    remain_pop_q <= remain_pop_q - NUM_WORD_WIDTH'(1);
                end
            end
            unique case (state_q)
                StIdle: begin
                    if (TOPITF_Start) begin
                        addr_q       <= TOPITF_BaseAddr;
                        remain_req_q <= TOPITF_NumWord;
                        remain_pop_q <= TOPITF_NumWord;
                        busy_q       <= 1'b1;
                        state_q      <= (TOPITF_NumWord == '0) ? StDone : StReq;
                    end
                end
                StReq: begin
                    if (req_hs) begin
                        addr_q       <= addr_q + DRAM_ADDR_WIDTH'(len) *
                                        DRAM_ADDR_WIDTH'(BytesPerWord);
                        remain_req_q <= remain_req_q - len_w;
                        if (remain_req_q == len_w) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (last_pop) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // FIFO storage needs no reset; pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= DRMITF_RdDat;
        end
    end

    assign ITFTOP_Busy         = busy_q;
    assign ITFTOP_Done         = done_q;
    assign ITFDRM_RdReqVld     = req_vld;
    assign ITFDRM_RdAddr       = addr_q;
    assign ITFDRM_RdLen        = len;
    assign ITFDRM_RdDatRdy     = !fifo_full;
    assign ITFCCU_ISARdDat     = mem_q[rd_ptr_q];
    assign ITFCCU_ISARdDatVld  = !fifo_empty;
    assign ITFCCU_ISARdDatLast = !fifo_empty && (remain_pop_q == NUM_WORD_WIDTH'(1));

endmodule

// File: tb/tb_isa_fetch.sv
// tb_isa_fetch: directed and randomized bench for isa_fetch with a transaction-level model
// of the expected word stream, request sequence, credit limit and busy/done timing.
module tb_isa_fetch;
    localparam int MB    = 8;
    localparam int DEPTH = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         TOPITF_Start;
    logic [31:0]  TOPITF_BaseAddr;
    logic [15:0]  TOPITF_NumWord;
    logic         ITFTOP_Busy, ITFTOP_Done;
    logic         ITFDRM_RdReqVld, DRMITF_RdReqRdy;
    logic [31:0]  ITFDRM_RdAddr;
    logic [7:0]   ITFDRM_RdLen;
    logic [127:0] DRMITF_RdDat;
    logic         DRMITF_RdDatVld, ITFDRM_RdDatRdy;
    logic [127:0] ITFCCU_ISARdDat;
    logic         ITFCCU_ISARdDatVld, ITFCCU_ISARdDatLast, CCUITF_ISARdDatRdy;

    always #5 clk = ~clk;

    isa_fetch #(
        .PORT_WIDTH     (128),
        .DRAM_ADDR_WIDTH(32),
        .NUM_WORD_WIDTH (16),
        .MAX_BURST      (MB),
        .FIFO_ADDR_WIDTH(4)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .TOPITF_Start       (TOPITF_Start),
        .TOPITF_BaseAddr    (TOPITF_BaseAddr),
        .TOPITF_NumWord     (TOPITF_NumWord),
        .ITFTOP_Busy        (ITFTOP_Busy),
        .ITFTOP_Done        (ITFTOP_Done),
        .ITFDRM_RdReqVld    (ITFDRM_RdReqVld),
        .DRMITF_RdReqRdy    (DRMITF_RdReqRdy),
        .ITFDRM_RdAddr      (ITFDRM_RdAddr),
        .ITFDRM_RdLen       (ITFDRM_RdLen),
        .DRMITF_RdDat       (DRMITF_RdDat),
        .DRMITF_RdDatVld    (DRMITF_RdDatVld),
        .ITFDRM_RdDatRdy    (ITFDRM_RdDatRdy),
        .ITFCCU_ISARdDat    (ITFCCU_ISARdDat),
        .ITFCCU_ISARdDatVld (ITFCCU_ISARdDatVld),
        .ITFCCU_ISARdDatLast(ITFCCU_ISARdDatLast),
        .CCUITF_ISARdDatRdy (CCUITF_ISARdDatRdy)
    );

    int n_checks = 0;
    int n_errs   = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // DRAM contents: a fixed function of the word's byte address.
    function automatic logic [127:0] dword(input logic [31:0] a);
        return {a ^ 32'hA5A5_0000, a * 32'h9E37_79B1, ~a, a + 32'h0000_1234};
    endfunction

    // Reference model: program progress counted in words, pending DRAM beats as addresses.
    logic        m_active, m_busy, m_done;
    int          m_n, m_reqd, m_recv, m_pop, m_fin;
    logic [31:0] m_base;
    logic [31:0] dq[$];
    int          p_ccu, p_dvld, p_rrdy;

    task automatic model_reset();
        m_active = 1'b0; m_busy = 1'b0; m_done = 1'b0;
        m_n = 0; m_reqd = 0; m_recv = 0; m_pop = 0; m_fin = 0;
        m_base = '0;
        dq.delete();
    endtask

    task automatic drive_inputs();
        TOPITF_Start       = 1'b0;
        CCUITF_ISARdDatRdy = ($urandom_range(99) < p_ccu);
        DRMITF_RdReqRdy    = ($urandom_range(99) < p_rrdy);
        if (dq.size() > 0 && $urandom_range(99) < p_dvld) begin
            DRMITF_RdDatVld = 1'b1;
            DRMITF_RdDat    = dword(dq[0]);
        end else begin
            DRMITF_RdDatVld = 1'b0;
            DRMITF_RdDat    = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    // Check the current cycle against the model, advance both across one clock edge.
    task automatic step();
        int          buffered, outst, len;
        logic        exp_req, req_hs, dat_hs, pop_hs, acc_start;
        logic [31:0] ea;
        buffered = m_recv - m_pop;
        outst    = m_reqd - m_recv;
        len      = (m_n - m_reqd > MB) ? MB : (m_n - m_reqd);
        exp_req  = m_active && (m_reqd < m_n) && (buffered + outst + len <= DEPTH);
        chk("busy", ITFTOP_Busy, m_busy);
        chk("done", ITFTOP_Done, m_done);
        chk("req_vld", ITFDRM_RdReqVld, exp_req);
        if (exp_req) begin
            ea = m_base + 32'(m_reqd * 16);
            chk("req_addr", ITFDRM_RdAddr, ea);
            chk("req_len", ITFDRM_RdLen, len);
        end
        chk("dat_rdy", ITFDRM_RdDatRdy, buffered != DEPTH);
        chk("isa_vld", ITFCCU_ISARdDatVld, buffered != 0);
        if (buffered != 0) begin
            ea = m_base + 32'(m_pop * 16);
            chk("isa_dat", ITFCCU_ISARdDat, dword(ea));
            chk("isa_last", ITFCCU_ISARdDatLast, m_pop == m_n - 1);
        end
        pop_hs    = (buffered != 0) && CCUITF_ISARdDatRdy;
        req_hs    = exp_req && DRMITF_RdReqRdy;
        dat_hs    = DRMITF_RdDatVld && (buffered != DEPTH);
        acc_start = TOPITF_Start && !m_active;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            m_done = 1'b0;
            if (dat_hs) begin
                void'(dq.pop_front());
                m_recv++;
            end
            if (req_hs) begin
                for (int i = 0; i < len; i++) dq.push_back(m_base + 32'((m_reqd + i) * 16));
                m_reqd += len;
            end
            if (pop_hs) m_pop++;
            if (m_fin == 1) begin
                m_fin = 0; m_done = 1'b1; m_busy = 1'b0; m_active = 1'b0;
            end else if (pop_hs && m_pop == m_n) begin
                m_fin = 1;
            end
            if (acc_start) begin
                m_active = 1'b1; m_busy = 1'b1;
                m_base = TOPITF_BaseAddr; m_n = int'(TOPITF_NumWord);
                m_reqd = 0; m_recv = 0; m_pop = 0;
                if (m_n == 0) m_fin = 1;
            end
        end
        @(negedge clk);
        drive_inputs();
        #2;
    endtask

    task automatic start(input logic [31:0] base, input int n);
        TOPITF_Start    = 1'b1;
        TOPITF_BaseAddr = base;
        TOPITF_NumWord  = 16'(n);
        step();
    endtask

    task automatic run_until_done(input int budget, input string tag);
        int c = 0;
        while (ITFTOP_Done !== 1'b1 && c < budget) begin
            step();
            c++;
        end
        chk({tag, "_timeout"}, c < budget, 1'b1);
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, ITFTOP_Busy, 1'b0);
        chk({tag, "_done"}, ITFTOP_Done, 1'b0);
        chk({tag, "_reqvld"}, ITFDRM_RdReqVld, 1'b0);
        chk({tag, "_addr"}, ITFDRM_RdAddr, 32'h0);
        chk({tag, "_len"}, ITFDRM_RdLen, 8'h0);
        chk({tag, "_isavld"}, ITFCCU_ISARdDatVld, 1'b0);
        chk({tag, "_last"}, ITFCCU_ISARdDatLast, 1'b0);
        chk({tag, "_datrdy"}, ITFDRM_RdDatRdy, 1'b1);
    endtask

    initial begin
        int c;
        rst = 1'b1;
        TOPITF_Start = 1'b0; TOPITF_BaseAddr = '0; TOPITF_NumWord = '0;
        DRMITF_RdReqRdy = 1'b0; DRMITF_RdDatVld = 1'b0; DRMITF_RdDat = '0;
        CCUITF_ISARdDatRdy = 1'b0;
        p_ccu = 100; p_dvld = 100; p_rrdy = 100;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive_inputs();
        #2;
        check_reset_outputs("rst");
        rst = 1'b0;
        step();

        // Short program, everything always ready.
        start(32'h1000, 3);
        run_until_done(100, "t1");

        // CCU stalled: two bursts fill the FIFO, the third waits for credit.
        p_ccu = 0;
        CCUITF_ISARdDatRdy = 1'b0;
        start(32'h1000, 20);
        repeat (40) step();
        chk("t2_full_noreq", ITFDRM_RdReqVld, 1'b0);
        chk("t2_full_vld", ITFCCU_ISARdDatVld, 1'b1);
        chk("t2_full_rdy", ITFDRM_RdDatRdy, 1'b0);
        p_ccu = 100;
        run_until_done(200, "t2");

        // Empty program.
        start(32'h5000, 0);
        chk("t3_busy", ITFTOP_Busy, 1'b1);
        chk("t3_noreq", ITFDRM_RdReqVld, 1'b0);
        step();
        chk("t3_done", ITFTOP_Done, 1'b1);
        chk("t3_busy_off", ITFTOP_Busy, 1'b0);
        step();
        chk("t3_done_off", ITFTOP_Done, 1'b0);

        // DRAM request stall; a second start in the window must be ignored.
        p_rrdy = 0;
        DRMITF_RdReqRdy = 1'b0;
        start(32'h2000, 10);
        for (int k = 0; k < 5; k++) begin
            chk("t4_vld", ITFDRM_RdReqVld, 1'b1);
            chk("t4_addr", ITFDRM_RdAddr, 32'h2000);
            chk("t4_len", ITFDRM_RdLen, 8'd8);
            if (k == 2) begin
                TOPITF_Start = 1'b1; TOPITF_BaseAddr = 32'h9000; TOPITF_NumWord = 16'd3;
            end
            step();
        end
        p_rrdy = 100;
        run_until_done(200, "t4");

        // Abort by reset mid-program, then a fresh program.
        start(32'h3000, 10);
        c = 0;
        while (m_pop < 5 && c < 100) begin
            step();
            c++;
        end
        chk("t5_reach5_timeout", c < 100, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_outputs("t5_rst");
        start(32'h4000, 2);
        run_until_done(100, "t5");

        // Randomized handshakes, including an address wrap.
        p_ccu = 30; p_dvld = 60; p_rrdy = 70;
        start(32'hFFFF_FF00, 40);
        run_until_done(3000, "t6a");
        p_ccu = 80; p_dvld = 50; p_rrdy = 50;
        start({$urandom} & 32'hFFFF_FFF0, 50);
        run_until_done(3000, "t6b");
        p_ccu = 55; p_dvld = 90; p_rrdy = 90;
        start({$urandom} & 32'hFFFF_FFF0, 33);
        run_until_done(3000, "t6c");
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
